// File: rtl/analog_probe_sequencer.sv
// analog_probe_sequencer
//   Controller for an analog probe. Each measurement issues 2**AVG_LOG2 sample
//   requests by inverting probe_toggle. After each request it waits SETTLE_CYCLES
//   cycles and then accumulates the signed reading on sample_in. At the end it
//   presents the floored average and the lo/hi window flags on a valid/ready
//   handshake.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   S_IDLE    | waiting for start; limits latched and accumulator cleared on start
//   S_REQUEST | invert probe_toggle, load settle counter
//   S_SETTLE  | count down SETTLE_CYCLES while the analog side settles
//   S_ACCUM   | add sample_in to accumulator, bump sample_idx
//   S_OUTPUT  | hold avg_data/flags/avg_valid until avg_ready
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   start, continuous     begin a measurement / re-arm after each accepted result
//   lo_limit, hi_limit    signed window bounds, latched when a measurement begins
//   probe_toggle          sample request, one inversion per sample
//   sample_in             signed probe reading in mV
//   busy, sample_idx      status: not idle / samples accumulated so far
//   avg_data, under_limit, over_limit, avg_valid, avg_ready   result handshake
module analog_probe_sequencer #(
    parameter int WIDTH         = 16,
    parameter int AVG_LOG2      = 2,
    parameter int SETTLE_CYCLES = 3
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    continuous,
    input  logic signed [WIDTH-1:0] lo_limit,
    input  logic signed [WIDTH-1:0] hi_limit,
    output logic                    probe_toggle,
    input  logic signed [WIDTH-1:0] sample_in,
    output logic                    busy,
    output logic [AVG_LOG2:0]       sample_idx,
    output logic signed [WIDTH-1:0] avg_data,
    output logic                    under_limit,
    output logic                    over_limit,
    output logic                    avg_valid,
    input  logic                    avg_ready
);

    localparam int ACC_W = WIDTH + AVG_LOG2;
    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
    localparam logic [AVG_LOG2:0] N_SAMPLES   = (AVG_LOG2 + 1)'(1 << AVG_LOG2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQUEST,
        S_SETTLE,
        S_ACCUM,
        S_OUTPUT
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        settle_cnt;
    logic signed [ACC_W-1:0] acc;
    logic signed [WIDTH-1:0] lo_q;
    logic signed [WIDTH-1:0] hi_q;

    logic signed [ACC_W-1:0] sample_ext;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [ACC_W-1:0] acc_shift;
    logic signed [WIDTH-1:0] avg_next;
    logic [AVG_LOG2:0]       idx_next;

    // The accumulator has AVG_LOG2 guard bits, so the sum of N full-scale readings
    // always fits. The shifted sum therefore always fits back into WIDTH bits.
    assign sample_ext = ACC_W'(sample_in);
    assign acc_sum    = acc + sample_ext;
    assign acc_shift  = acc_sum >>> AVG_LOG2;
    assign avg_next   = acc_shift[WIDTH-1:0];
    assign idx_next   = sample_idx + (AVG_LOG2 + 1)'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            settle_cnt   <= '0;
            acc          <= '0;
            lo_q         <= '0;
            hi_q         <= '0;
            probe_toggle <= 1'b0;
            busy         <= 1'b0;
            sample_idx   <= '0;
            avg_data     <= '0;
            under_limit  <= 1'b0;
            over_limit   <= 1'b0;
            avg_valid    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_REQUEST;
                        busy       <= 1'b1;
                        acc        <= '0;
                        sample_idx <= '0;
                        lo_q       <= lo_limit;
                        hi_q       <= hi_limit;
                    end
                end
                S_REQUEST: begin
                    probe_toggle <= ~probe_toggle;
                    settle_cnt   <= SETTLE_LOAD;
                    state        <= S_SETTLE;
                end
                S_SETTLE: begin
                    settle_cnt <= settle_cnt - CNT_W'(1);
                    if (settle_cnt == CNT_W'(1)) begin
                        state <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    acc        <= acc_sum;
                    sample_idx <= idx_next;
                    if (idx_next == N_SAMPLES) begin
                        // Result is taken from the sum including this sample, so it
                        // is registered on the same edge as entry to S_OUTPUT.
                        state       <= S_OUTPUT;
                        avg_data    <= avg_next;
                        under_limit <= (avg_next < lo_q);
                        over_limit  <= (avg_next > hi_q);
                        avg_valid   <= 1'b1;
                    end else begin
                        state <= S_REQUEST;
                    end
                end
                S_OUTPUT: begin
                    if (avg_ready) begin
                        avg_valid <= 1'b0;
                        if (continuous) begin
                            state      <= S_REQUEST;
                            acc        <= '0;
                            sample_idx <= '0;
                            lo_q       <= lo_limit;
                            hi_q       <= hi_limit;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_analog_probe_sequencer.sv
// tb_analog_probe_sequencer
//   Directed bench for analog_probe_sequencer with default parameters. It plays the
//   analog side: each time probe_toggle changes, it presents the next value from a
//   four-entry sample table on sample_in.
module tb_analog_probe_sequencer;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               start = 1'b0;
    logic               continuous = 1'b0;
    logic signed [15:0] lo_limit = '0;
    logic signed [15:0] hi_limit = '0;
    logic               probe_toggle;
    logic signed [15:0] sample_in = '0;
    logic               busy;
    logic [2:0]         sample_idx;
    logic signed [15:0] avg_data;
    logic               under_limit;
    logic               over_limit;
    logic               avg_valid;
    logic               avg_ready = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    int seq [4];
    int seq_base  = 0;
    int tog_total = 0;
    logic tog_last = 1'b0;

    analog_probe_sequencer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .continuous   (continuous),
        .lo_limit     (lo_limit),
        .hi_limit     (hi_limit),
        .probe_toggle (probe_toggle),
        .sample_in    (sample_in),
        .busy         (busy),
        .sample_idx   (sample_idx),
        .avg_data     (avg_data),
        .under_limit  (under_limit),
        .over_limit   (over_limit),
        .avg_valid    (avg_valid),
        .avg_ready    (avg_ready)
    );

    always #5 clk = ~clk;

    // Analog side: present the next table entry after every probe request.
    always @(negedge clk) begin
        if (probe_toggle !== tog_last) begin
            sample_in = 16'(seq[(tog_total - seq_base) & 3]);
            tog_total = tog_total + 1;
            tog_last  = probe_toggle;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_seq(input int a, input int b, input int c, input int d);
        seq[0]   = a;
        seq[1]   = b;
        seq[2]   = c;
        seq[3]   = d;
        seq_base = tog_total;
    endtask

    // Pulse start. Return the number of edges from the edge that samples start to
    // the edge where avg_valid is seen. Optionally re-pulse start at edge restart_at.
    task automatic run_measure(input int restart_at, output int cycles);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cycles = 0;
        while (!avg_valid && cycles < 200) begin
            start = (restart_at != 0) && (cycles + 1 == restart_at);
            @(posedge clk); #1;
            cycles++;
        end
        start = 1'b0;
    endtask

    task automatic handshake(input logic cont, input logic with_start);
        avg_ready  = 1'b1;
        continuous = cont;
        start      = with_start;
        @(posedge clk); #1;
        avg_ready = 1'b0;
        start     = 1'b0;
    endtask

    initial begin
        int   cyc;
        int   base;
        int   guard;
        logic lvl;

        #12;
        check("rst_toggle", probe_toggle, 0);
        check("rst_busy", busy, 0);
        check("rst_idx", sample_idx, 0);
        check("rst_avg", avg_data, 0);
        check("rst_valid", avg_valid, 0);
        check("rst_flags", {under_limit, over_limit}, 0);
        reset_n = 1'b1;

        // Constant 1000, inside the window.
        lo_limit = 900; hi_limit = 1100;
        set_seq(1000, 1000, 1000, 1000);
        base = tog_total;
        run_measure(0, cyc);
        check("t1_latency", cyc, 20);
        check("t1_avg", avg_data, 1000);
        check("t1_flags", {under_limit, over_limit}, 0);
        check("t1_idx", sample_idx, 4);
        check("t1_toggles", tog_total - base, 4);
        handshake(1'b0, 1'b0);
        check("t1_valid_drop", avg_valid, 0);
        check("t1_idle", busy, 0);

        // Negative sum -7 must floor to -2.
        lo_limit = -10; hi_limit = 10;
        set_seq(-1, -2, -2, -2);
        run_measure(0, cyc);
        check("t2_latency", cyc, 20);
        check("t2_avg", avg_data, -2);
        check("t2_flags", {under_limit, over_limit}, 0);
        handshake(1'b0, 1'b0);

        // Stall, then continuous re-arm (start in the same cycle is ignored).
        lo_limit = 0; hi_limit = 1000;
        set_seq(500, 500, 500, 500);
        base = tog_total;
        run_measure(0, cyc);
        repeat (10) @(posedge clk);
        #1;
        check("t3_stall_avg", avg_data, 500);
        check("t3_stall_valid", avg_valid, 1);
        check("t3_stall_toggles", tog_total - base, 4);
        lvl = probe_toggle;
        handshake(1'b1, 1'b1);
        check("t3_hs_valid", avg_valid, 0);
        check("t3_hs_busy", busy, 1);
        check("t3_hs_toggle_held", probe_toggle, lvl);
        continuous = 1'b0;
        @(posedge clk); #1;
        check("t3_next_toggle", probe_toggle, !lvl);
        cyc = 0;
        while (!avg_valid && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("t3_rearm_latency", cyc, 19);
        check("t3_rearm_avg", avg_data, 500);
        check("t3_rearm_toggles", tog_total - base, 8);
        handshake(1'b0, 1'b0);
        check("t3_single_result", busy, 0);

        // Full-scale negative and positive, no overflow.
        lo_limit = -100; hi_limit = 100;
        set_seq(-32768, -32768, -32768, -32768);
        run_measure(0, cyc);
        check("t4_neg_avg", avg_data, -32768);
        check("t4_neg_flags", {under_limit, over_limit}, 2);
        handshake(1'b0, 1'b0);
        set_seq(32767, 32767, 32767, 32767);
        run_measure(0, cyc);
        check("t4_pos_avg", avg_data, 32767);
        check("t4_pos_flags", {under_limit, over_limit}, 1);
        handshake(1'b0, 1'b0);

        // Inverted window: both flags.
        lo_limit = 200; hi_limit = 100;
        set_seq(100, 200, 150, 150);
        run_measure(0, cyc);
        check("t5_avg", avg_data, 150);
        check("t5_flags", {under_limit, over_limit}, 3);
        handshake(1'b0, 1'b0);

        // Reset during SETTLE of sample 2.
        lo_limit = 0; hi_limit = 2000;
        set_seq(1000, 1000, 1000, 1000);
        base = tog_total;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        guard = 0;
        while ((tog_total - base) < 2 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("t6_reached_sample2", tog_total - base, 2);
        #1 reset_n = 1'b0;
        #1;
        check("t6_rst_toggle", probe_toggle, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_idx", sample_idx, 0);
        check("t6_rst_avg", avg_data, 0);
        check("t6_rst_valid", avg_valid, 0);
        check("t6_rst_flags", {under_limit, over_limit}, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        set_seq(1000, 1000, 1000, 1000);
        base = tog_total;
        run_measure(5, cyc);
        check("t6_fresh_latency", cyc, 20);
        check("t6_fresh_avg", avg_data, 1000);
        check("t6_fresh_idx", sample_idx, 4);
        check("t6_fresh_toggles", tog_total - base, 4);
        lvl = probe_toggle;
        handshake(1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("t6_hs_start_busy", busy, 0);
        check("t6_hs_start_valid", avg_valid, 0);
        check("t6_hs_start_toggle", probe_toggle, lvl);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
